axi3_hp_responder: RTL and testbench



---
 rtl/axi3_pkg.sv | 26 ++
 rtl/axi_resp_ram.sv | 39 +++
 rtl/axi3_hp_responder.sv | 256 +++++++++++++++++++++++++
 tb/tb_axi3_hp_responder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi3_pkg.sv
// Shared constants, state encodings and the captured-burst record for the
// AXI3 HP responder.
package axi3_pkg;

  localparam int unsigned WADDR_W = 29;  // 64-bit word address width
  localparam int unsigned ID_W    = 6;
  localparam int unsigned LEN_W   = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_8B     = 3'b011;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

  // Burst fields latched at the address handshake
  typedef struct packed {
    logic [WADDR_W-1:0] addr;
    logic [ID_W-1:0]    id;
    logic [LEN_W-1:0]   len;
    logic               illegal;  // size != 8 bytes or burst != INCR
  } burst_t;

endpackage

// File: rtl/axi_resp_ram.sv
// Simple dual-port RAM: port A byte-enabled write, port B registered read.
// Ports: clk_i/rst_ni; we/waddr/wbe/wdata write port; re/rclr/raddr read
// request; rdata registered read data (rclr loads zero instead of memory).
module axi_resp_ram #(
  parameter int unsigned AW = 12
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wbe,
  input  logic [63:0]   wdata,
  input  logic          re,
  input  logic          rclr,
  input  logic [AW-1:0] raddr,
  output logic [63:0]   rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [63:0] mem [DEPTH];

  // Byte-lane writes; the array itself is not reset so contents survive reset
  always_ff @(posedge clk_i) begin
    if (we) begin
      for (int b = 0; b < 8; b++) begin
        if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read register samples the array before a same-edge write lands
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata <= '0;
    else if (rclr) rdata <= '0;
    else if (re)   rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi3_hp_responder.sv
// AXI3 64-bit slave terminating an HP master port with local memory.
// Ports: clk_i/rst_ni; s_axi_aw*/w*/b* write channels; s_axi_ar*/r* read
// channels; err_o sticky flag for any non-OKAY B or R response.
module axi3_hp_responder
  import axi3_pkg::*;
#(
  parameter logic [31:0] BASE   = 32'h2000_0000,
  parameter int unsigned MEM_AW = 12
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_awaddr,
  input  logic [3:0]  s_axi_awlen,
  input  logic [2:0]  s_axi_awsize,
  input  logic [1:0]  s_axi_awburst,
  input  logic [5:0]  s_axi_awid,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  input  logic [63:0] s_axi_wdata,
  input  logic [7:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  input  logic [5:0]  s_axi_wid,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  output logic [1:0]  s_axi_bresp,
  output logic [5:0]  s_axi_bid,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [31:0] s_axi_araddr,
  input  logic [3:0]  s_axi_arlen,
  input  logic [2:0]  s_axi_arsize,
  input  logic [1:0]  s_axi_arburst,
  input  logic [5:0]  s_axi_arid,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [63:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic [5:0]  s_axi_rid,
  output logic        s_axi_rlast,
  output logic        err_o
);

  localparam logic [WADDR_W-1:0] BASE_WORD = BASE[31:3];
  localparam logic [WADDR_W-1:0] DEPTH     = WADDR_W'(1) << MEM_AW;

  function automatic logic in_window(input logic [WADDR_W-1:0] a);
    return (a - BASE_WORD) < DEPTH;
  endfunction

  // Byte offset bits are don't-care for 8-byte beats
  logic unused_c;
  assign unused_c = ^{s_axi_awaddr[2:0], s_axi_araddr[2:0]};

  w_state_e         w_state, w_state_d;
  burst_t           wb, wb_d;
  logic [LEN_W-1:0] w_cnt, w_cnt_d;
  logic             w_dec, w_dec_d, w_slv, w_slv_d;
  logic             awready_d, wready_d, bvalid_d;
  logic [1:0]       bresp_d;
  logic [ID_W-1:0]  bid_d;
  logic             w_last_c, w_viol_c, aw_dec_c, ram_we_c;

  r_state_e         r_state, r_state_d;
  burst_t           rb, rb_d;
  logic [LEN_W-1:0] r_cnt, r_cnt_d;
  logic             arready_d, rvalid_d, rlast_d;
  logic [1:0]       rresp_d;
  logic [ID_W-1:0]  rid_d;
  logic             r_dec_c, ram_re_c, ram_rclr_c;
  logic             err_d;

  logic [MEM_AW-1:0] ram_waddr_c, ram_raddr_c;
  assign ram_waddr_c = MEM_AW'(wb.addr - BASE_WORD);
  assign ram_raddr_c = MEM_AW'(rb.addr - BASE_WORD);

  // Window is contiguous, so a burst is fully inside iff first and last beat are
  assign aw_dec_c = !(in_window(s_axi_awaddr[31:3]) &&
                      in_window(s_axi_awaddr[31:3] + WADDR_W'(s_axi_awlen)));
  assign w_last_c = (w_cnt == wb.len);
  assign w_viol_c = (s_axi_wlast != w_last_c) || (s_axi_wid != wb.id);
  assign r_dec_c  = !in_window(rb.addr);

  // Write path next state and outputs
  always_comb begin
    w_state_d = w_state;
    wb_d      = wb;
    w_cnt_d   = w_cnt;
    w_dec_d   = w_dec;
    w_slv_d   = w_slv;
    awready_d = s_axi_awready;
    wready_d  = s_axi_wready;
    bvalid_d  = s_axi_bvalid;
    bresp_d   = s_axi_bresp;
    bid_d     = s_axi_bid;
    ram_we_c  = 1'b0;
    case (w_state)
      W_IDLE: begin
        awready_d = 1'b1;
        if (s_axi_awvalid && s_axi_awready) begin
          wb_d.addr    = s_axi_awaddr[31:3];
          wb_d.id      = s_axi_awid;
          wb_d.len     = s_axi_awlen;
          wb_d.illegal = (s_axi_awsize != SIZE_8B) || (s_axi_awburst != BURST_INCR);
          w_cnt_d      = '0;
          w_dec_d      = aw_dec_c;
          w_slv_d      = 1'b0;
          awready_d    = 1'b0;
          wready_d     = 1'b1;
          w_state_d    = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid && s_axi_wready) begin
          ram_we_c = !(w_dec || wb.illegal);
          w_slv_d  = w_slv || w_viol_c;
          if (w_last_c) begin
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bid_d     = wb.id;
            bresp_d   = w_dec ? RESP_DECERR :
                        (wb.illegal || w_slv || w_viol_c) ? RESP_SLVERR : RESP_OKAY;
            w_state_d = W_RESP;
          end else begin
            w_cnt_d   = w_cnt + 4'd1;
            wb_d.addr = wb.addr + 29'd1;
          end
        end
      end
      W_RESP: begin
        if (s_axi_bvalid && s_axi_bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read path next state and outputs; one beat per fetch/data pair
  always_comb begin
    r_state_d  = r_state;
    rb_d       = rb;
    r_cnt_d    = r_cnt;
    arready_d  = s_axi_arready;
    rvalid_d   = s_axi_rvalid;
    rlast_d    = s_axi_rlast;
    rresp_d    = s_axi_rresp;
    rid_d      = s_axi_rid;
    ram_re_c   = 1'b0;
    ram_rclr_c = 1'b0;
    case (r_state)
      R_IDLE: begin
        arready_d = 1'b1;
        if (s_axi_arvalid && s_axi_arready) begin
          rb_d.addr    = s_axi_araddr[31:3];
          rb_d.id      = s_axi_arid;
          rb_d.len     = s_axi_arlen;
          rb_d.illegal = (s_axi_arsize != SIZE_8B) || (s_axi_arburst != BURST_INCR);
          r_cnt_d      = '0;
          arready_d    = 1'b0;
          r_state_d    = R_FETCH;
        end
      end
      R_FETCH: begin
        ram_re_c   = 1'b1;
        ram_rclr_c = r_dec_c || rb.illegal;
        rvalid_d   = 1'b1;
        rlast_d    = (r_cnt == rb.len);
        rid_d      = rb.id;
        rresp_d    = r_dec_c ? RESP_DECERR : rb.illegal ? RESP_SLVERR : RESP_OKAY;
        r_state_d  = R_DATA;
      end
      R_DATA: begin
        if (s_axi_rvalid && s_axi_rready) begin
          rvalid_d = 1'b0;
          rlast_d  = 1'b0;
          if (s_axi_rlast) begin
            arready_d = 1'b1;
            r_state_d = R_IDLE;
          end else begin
            r_cnt_d   = r_cnt + 4'd1;
            rb_d.addr = rb.addr + 29'd1;
            r_state_d = R_FETCH;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign err_d = err_o ||
                 (s_axi_bvalid && s_axi_bready && (s_axi_bresp != RESP_OKAY)) ||
                 (s_axi_rvalid && s_axi_rready && (s_axi_rresp != RESP_OKAY));

  // State and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state       <= W_IDLE;
      wb            <= '0;
      w_cnt         <= '0;
      w_dec         <= 1'b0;
      w_slv         <= 1'b0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      s_axi_bid     <= '0;
      r_state       <= R_IDLE;
      rb            <= '0;
      r_cnt         <= '0;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rid     <= '0;
      err_o         <= 1'b0;
    end else begin
      w_state       <= w_state_d;
      wb            <= wb_d;
      w_cnt         <= w_cnt_d;
      w_dec         <= w_dec_d;
      w_slv         <= w_slv_d;
      s_axi_awready <= awready_d;
      s_axi_wready  <= wready_d;
      s_axi_bvalid  <= bvalid_d;
      s_axi_bresp   <= bresp_d;
      s_axi_bid     <= bid_d;
      r_state       <= r_state_d;
      rb            <= rb_d;
      r_cnt         <= r_cnt_d;
      s_axi_arready <= arready_d;
      s_axi_rvalid  <= rvalid_d;
      s_axi_rlast   <= rlast_d;
      s_axi_rresp   <= rresp_d;
      s_axi_rid     <= rid_d;
      err_o         <= err_d;
    end
  end

  axi_resp_ram #(.AW(MEM_AW)) u_ram (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .we    (ram_we_c),
    .waddr (ram_waddr_c),
    .wbe   (s_axi_wstrb),
    .wdata (s_axi_wdata),
    .re    (ram_re_c),
    .rclr  (ram_rclr_c),
    .raddr (ram_raddr_c),
    .rdata (s_axi_rdata)
  );

endmodule

// File: tb/tb_axi3_hp_responder.sv
// Directed self-checking bench for axi3_hp_responder.
module tb_axi3_hp_responder;

  localparam logic [31:0] BASE = 32'h2000_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        s_axi_awvalid = 1'b0, s_axi_awready;
  logic [31:0] s_axi_awaddr = '0;
  logic [3:0]  s_axi_awlen = '0;
  logic [2:0]  s_axi_awsize = 3'b011;
  logic [1:0]  s_axi_awburst = 2'b01;
  logic [5:0]  s_axi_awid = '0;
  logic        s_axi_wvalid = 1'b0, s_axi_wready;
  logic [63:0] s_axi_wdata = '0;
  logic [7:0]  s_axi_wstrb = '0;
  logic        s_axi_wlast = 1'b0;
  logic [5:0]  s_axi_wid = '0;
  logic        s_axi_bvalid, s_axi_bready = 1'b0;
  logic [1:0]  s_axi_bresp;
  logic [5:0]  s_axi_bid;
  logic        s_axi_arvalid = 1'b0, s_axi_arready;
  logic [31:0] s_axi_araddr = '0;
  logic [3:0]  s_axi_arlen = '0;
  logic [2:0]  s_axi_arsize = 3'b011;
  logic [1:0]  s_axi_arburst = 2'b01;
  logic [5:0]  s_axi_arid = '0;
  logic        s_axi_rvalid, s_axi_rready = 1'b0;
  logic [63:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic [5:0]  s_axi_rid;
  logic        s_axi_rlast;
  logic        err_o;

  always #5 clk_i = ~clk_i;

  axi3_hp_responder #(.BASE(BASE), .MEM_AW(12)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awid(s_axi_awid),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wlast(s_axi_wlast), .s_axi_wid(s_axi_wid),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bid(s_axi_bid),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arid(s_axi_arid),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rid(s_axi_rid), .s_axi_rlast(s_axi_rlast),
    .err_o(err_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] wbuf     [16];
  logic [63:0] rbuf     [16];
  logic [1:0]  rrespbuf [16];
  logic        rlastbuf [16];
  logic [5:0]  ridbuf   [16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Full write burst; wlast is driven on beat last_at, wid may differ from id
  task automatic axi_write(input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input logic [7:0] strb,
                           input logic [5:0] id, input logic [5:0] wid, input int last_at,
                           output logic [1:0] resp, output logic [5:0] bid);
    int n;
    s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awburst = burst;
    s_axi_awsize = 3'b011; s_axi_awid = id; s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 50) begin tick(); n++; end
    check("aw_ready_seen", 64'(s_axi_awready), 64'd1);
    tick();
    s_axi_awvalid = 1'b0;
    check("wready_after_aw", 64'(s_axi_wready), 64'd1);
    for (int i = 0; i <= int'(len); i++) begin
      s_axi_wdata = wbuf[i]; s_axi_wstrb = strb; s_axi_wid = wid;
      s_axi_wlast = (i == last_at); s_axi_wvalid = 1'b1;
      n = 0;
      while (!s_axi_wready && n < 50) begin tick(); n++; end
      if (n >= 50) check("w_beat_timeout", 64'(s_axi_wready), 64'd1);
      tick();
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    check("bvalid_after_last_w", 64'(s_axi_bvalid), 64'd1);
    s_axi_bready = 1'b1;
    n = 0;
    while (!s_axi_bvalid && n < 50) begin tick(); n++; end
    resp = s_axi_bresp; bid = s_axi_bid;
    tick();
    s_axi_bready = 1'b0;
    check("awready_after_b", 64'(s_axi_awready), 64'd1);
  endtask

  // Full read burst into rbuf; optionally withholds rready on one beat
  task automatic axi_read(input logic [31:0] addr, input logic [3:0] len,
                          input logic [5:0] id, input int stall_beat, input int stall_cycles);
    int n;
    s_axi_araddr = addr; s_axi_arlen = len; s_axi_arid = id;
    s_axi_arsize = 3'b011; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 50) begin tick(); n++; end
    check("ar_ready_seen", 64'(s_axi_arready), 64'd1);
    tick();
    s_axi_arvalid = 1'b0;
    check("rvalid_low_t1", 64'(s_axi_rvalid), 64'd0);
    s_axi_rready = 1'b1;
    tick();
    check("rvalid_high_t2", 64'(s_axi_rvalid), 64'd1);
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (!s_axi_rvalid && n < 50) begin tick(); n++; end
      if (n >= 50) check("r_beat_timeout", 64'(s_axi_rvalid), 64'd1);
      rbuf[i] = s_axi_rdata; rrespbuf[i] = s_axi_rresp;
      rlastbuf[i] = s_axi_rlast; ridbuf[i] = s_axi_rid;
      if (i == stall_beat) begin
        s_axi_rready = 1'b0;
        repeat (stall_cycles) begin
          tick();
          check("stall_rvalid", 64'(s_axi_rvalid), 64'd1);
          check("stall_rdata", s_axi_rdata, rbuf[i]);
        end
        s_axi_rready = 1'b1;
      end
      tick();
    end
    s_axi_rready = 1'b0;
    check("arready_after_rlast", 64'(s_axi_arready), 64'd1);
  endtask

  logic [1:0] resp;
  logic [5:0] bidv;

  initial begin
    // Reset state
    tick(); tick();
    check("rst_awready", 64'(s_axi_awready), 64'd0);
    check("rst_arready", 64'(s_axi_arready), 64'd0);
    check("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
    check("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
    check("rst_rdata", s_axi_rdata, 64'd0);
    check("rst_err", 64'(err_o), 64'd0);
    rst_ni = 1'b1;
    check("rel_awready_still_low", 64'(s_axi_awready), 64'd0);
    tick();
    check("rel_awready", 64'(s_axi_awready), 64'd1);
    check("rel_arready", 64'(s_axi_arready), 64'd1);

    // 4-beat write and readback
    wbuf[0] = 64'h0123_4567_89AB_CDEF; wbuf[1] = 64'hDEAD_BEEF_0000_0001;
    wbuf[2] = 64'hCAFE_F00D_1234_5678; wbuf[3] = 64'h5555_AAAA_3333_CCCC;
    axi_write(BASE, 4'd3, 2'b01, 8'hFF, 6'd5, 6'd5, 3, resp, bidv);
    check("wr4_bresp", 64'(resp), 64'd0);
    check("wr4_bid", 64'(bidv), 64'd5);
    axi_read(BASE, 4'd3, 6'd7, -1, 0);
    check("rd4_d0", rbuf[0], 64'h0123_4567_89AB_CDEF);
    check("rd4_d1", rbuf[1], 64'hDEAD_BEEF_0000_0001);
    check("rd4_d2", rbuf[2], 64'hCAFE_F00D_1234_5678);
    check("rd4_d3", rbuf[3], 64'h5555_AAAA_3333_CCCC);
    for (int i = 0; i < 4; i++) begin
      check("rd4_rlast", 64'(rlastbuf[i]), (i == 3) ? 64'd1 : 64'd0);
      check("rd4_rresp", 64'(rrespbuf[i]), 64'd0);
      check("rd4_rid", 64'(ridbuf[i]), 64'd7);
    end
    check("rd4_err", 64'(err_o), 64'd0);

    // Partial strobe over all-ones
    wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    axi_write(BASE + 32'h100, 4'd0, 2'b01, 8'hFF, 6'd1, 6'd1, 0, resp, bidv);
    wbuf[0] = 64'h0;
    axi_write(BASE + 32'h100, 4'd0, 2'b01, 8'h0F, 6'd1, 6'd1, 0, resp, bidv);
    check("strb_bresp", 64'(resp), 64'd0);
    axi_read(BASE + 32'h100, 4'd0, 6'd2, -1, 0);
    check("strb_data", rbuf[0], 64'hFFFF_FFFF_0000_0000);

    // Read just below the window
    axi_read(BASE - 32'd8, 4'd0, 6'd3, -1, 0);
    check("dec_rresp", 64'(rrespbuf[0]), 64'd3);
    check("dec_rdata", rbuf[0], 64'd0);
    check("dec_rlast", 64'(rlastbuf[0]), 64'd1);
    tick();
    check("dec_err", 64'(err_o), 64'd1);

    // WRAP burst type is rejected and does not touch memory
    wbuf[0] = 64'h1234;
    axi_write(BASE + 32'h100, 4'd0, 2'b10, 8'hFF, 6'd4, 6'd4, 0, resp, bidv);
    check("wrap_bresp", 64'(resp), 64'd2);
    axi_read(BASE + 32'h100, 4'd0, 6'd4, -1, 0);
    check("wrap_mem_kept", rbuf[0], 64'hFFFF_FFFF_0000_0000);

    // 16-beat write, then 16-beat read stalled on beat 3
    for (int i = 0; i < 16; i++) wbuf[i] = {32'hC0DE_0000 + 32'(i), 32'(i * 3)};
    axi_write(BASE + 32'h200, 4'd15, 2'b01, 8'hFF, 6'd8, 6'd8, 15, resp, bidv);
    check("wr16_bresp", 64'(resp), 64'd0);
    axi_read(BASE + 32'h200, 4'd15, 6'd9, 2, 5);
    for (int i = 0; i < 16; i++) begin
      check("rd16_data", rbuf[i], {32'hC0DE_0000 + 32'(i), 32'(i * 3)});
      check("rd16_rlast", 64'(rlastbuf[i]), (i == 15) ? 64'd1 : 64'd0);
    end

    // Early wlast: burst still runs its full length, answered with SLVERR
    for (int i = 0; i < 4; i++) wbuf[i] = 64'(i);
    axi_write(BASE + 32'h400, 4'd3, 2'b01, 8'hFF, 6'd9, 6'd9, 1, resp, bidv);
    check("wlast_bresp", 64'(resp), 64'd2);
    check("wlast_bid", 64'(bidv), 64'd9);

    // Write ID mismatch
    axi_write(BASE + 32'h500, 4'd1, 2'b01, 8'hFF, 6'd4, 6'd6, 1, resp, bidv);
    check("wid_bresp", 64'(resp), 64'd2);

    // Last word of the window, then a burst running past it
    wbuf[0] = 64'hA5A5_A5A5_5A5A_5A5A;
    axi_write(BASE + 32'h7FF8, 4'd0, 2'b01, 8'hFF, 6'd2, 6'd2, 0, resp, bidv);
    check("top_bresp", 64'(resp), 64'd0);
    wbuf[0] = 64'h0; wbuf[1] = 64'h0;
    axi_write(BASE + 32'h7FF8, 4'd1, 2'b01, 8'hFF, 6'd2, 6'd2, 1, resp, bidv);
    check("over_bresp", 64'(resp), 64'd3);
    axi_read(BASE + 32'h7FF8, 4'd0, 6'd1, -1, 0);
    check("top_rresp", 64'(rrespbuf[0]), 64'd0);
    check("top_data_kept", rbuf[0], 64'hA5A5_A5A5_5A5A_5A5A);
    check("err_sticky", 64'(err_o), 64'd1);

    // Reset in the middle of a write burst
    s_axi_awaddr = BASE; s_axi_awlen = 4'd3; s_axi_awburst = 2'b01;
    s_axi_awid = 6'd1; s_axi_awvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    check("abort_wready_before", 64'(s_axi_wready), 64'd1);
    rst_ni = 1'b0;
    #1;
    check("abort_wready", 64'(s_axi_wready), 64'd0);
    check("abort_awready", 64'(s_axi_awready), 64'd0);
    check("abort_err", 64'(err_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
